// File: rtl/radio_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : radio_spi_pkg
// Description : Shared encodings and widths for the radio board SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
package radio_spi_pkg;

    // Chip-select target encoding on spi_target
    localparam logic TARGET_RADIO = 1'b0;
    localparam logic TARGET_DAC   = 1'b1;

    // Default word lengths for the two slaves
    localparam int RADIO_BITS_DEFAULT = 18;
    localparam int DAC_BITS_DEFAULT   = 16;

    // Width of the word port and the internal counters
    localparam int WORD_W = 18;
    localparam int HPC_W  = 8;
    localparam int BIT_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/radio_spi_halfper_ctr.sv
`default_nettype none
// ============================================================================
// Module      : radio_spi_halfper_ctr
// Description : Half-period down-counter. Loaded with CLK_DIV-1 whenever the
//               state machine enters a new state; tc flags the last cycle of
//               the current state visit.
// Revision    : 1.0 - initial release
// ============================================================================
module radio_spi_halfper_ctr
    import radio_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tc
);

    localparam logic [HPC_W-1:0] LOAD_VAL = HPC_W'(CLK_DIV - 1);

    logic [HPC_W-1:0] count;

    // Count down to zero and hold; a load restarts the half period
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule
`default_nettype wire

// File: rtl/radio_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : radio_spi_master
// Description : Serialises one register word at a time to either the MAX2829
//               transceiver or the AD9777 DAC, MSB (index 0) first. Data is
//               launched on SPI clock falling edges and sampled by the slave
//               on rising edges.
// Revision    : 1.0 - initial release
// ============================================================================
module radio_spi_master
    import radio_spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int RADIO_BITS = RADIO_BITS_DEFAULT,
    parameter int DAC_BITS   = DAC_BITS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_start,
    input  logic              spi_target,
    input  logic [0:WORD_W-1] spi_wdata,
    output logic              spi_busy,
    output logic              spi_done,
    output logic              controller_spi_clk,
    output logic              controller_spi_data,
    output logic              controller_radio_cs,
    output logic              controller_dac_cs
);

    state_t            state;
    logic [WORD_W-1:0] shreg;      // shreg[WORD_W-1] holds the bit currently on the wire
    logic [BIT_W-1:0]  bits_left;  // rising edges still to be produced, including the current one
    logic              ctr_load;
    logic              ctr_tc;

    // Restart the half-period count on acceptance and on every state change
    assign ctr_load = ((state == ST_IDLE) && spi_start) || ((state != ST_IDLE) && ctr_tc);

    radio_spi_halfper_ctr #(
        .CLK_DIV (CLK_DIV)
    ) u_halfper_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (ctr_load),
        .tc    (ctr_tc)
    );

    // Transfer state machine with registered SPI and handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= ST_IDLE;
            shreg               <= '0;
            bits_left           <= '0;
            spi_busy            <= 1'b0;
            spi_done            <= 1'b0;
            controller_spi_clk  <= 1'b0;
            controller_spi_data <= 1'b0;
            controller_radio_cs <= 1'b1;
            controller_dac_cs   <= 1'b1;
        end else begin
            spi_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (spi_start) begin
                        shreg               <= spi_wdata;
                        bits_left           <= (spi_target == TARGET_DAC) ? BIT_W'(DAC_BITS)
                                                                          : BIT_W'(RADIO_BITS);
                        spi_busy            <= 1'b1;
                        controller_radio_cs <= (spi_target != TARGET_RADIO);
                        controller_dac_cs   <= (spi_target != TARGET_DAC);
                        controller_spi_data <= spi_wdata[0];
                        state               <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (ctr_tc) begin
                        controller_spi_clk <= 1'b1;
                        state              <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    // Falling edge: advance data together with clk going low
                    if (ctr_tc) begin
                        controller_spi_clk  <= 1'b0;
                        controller_spi_data <= shreg[WORD_W-2];
                        shreg               <= {shreg[WORD_W-2:0], 1'b0};
                        state               <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (ctr_tc) begin
                        if (bits_left > BIT_W'(1)) begin
                            bits_left          <= bits_left - 1'b1;
                            controller_spi_clk <= 1'b1;
                            state              <= ST_HIGH;
                        end else begin
                            controller_radio_cs <= 1'b1;
                            controller_dac_cs   <= 1'b1;
                            controller_spi_data <= 1'b0;
                            state               <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (ctr_tc) begin
                        spi_busy <= 1'b0;
                        spi_done <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
